// File: rtl/counter_bank_param_if.sv
// counter_bank_param_if
// Control and status bundle for counter_bank_param.
//   en, dir, cascade, load : control strobes (master -> bank)
//   load_val               : parallel load value, channel k at [k*WIDTH +: WIDTH]
//   count_out              : registered channel values, same packing as load_val
//   wrap_out               : per-channel one-cycle wrap pulse
//   all_wrap               : one-cycle pulse when every channel wrapped together
interface counter_bank_param_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3
);
  logic                      en;
  logic                      dir;
  logic                      cascade;
  logic                      load;
  logic [WIDTH*CHANNELS-1:0] load_val;
  logic [WIDTH*CHANNELS-1:0] count_out;
  logic [CHANNELS-1:0]       wrap_out;
  logic                      all_wrap;

  modport master (
    output en, dir, cascade, load, load_val,
    input  count_out, wrap_out, all_wrap
  );

  modport slave (
    input  en, dir, cascade, load, load_val,
    output count_out, wrap_out, all_wrap
  );
endinterface

// File: rtl/counter_bank_param.sv
// counter_bank_param
// Bank of CHANNELS WIDTH-bit up/down counters that either step independently
// or ripple together as one WIDTH*CHANNELS-bit counter (channel 0 = LSB).
// Per edge priority: load > en > hold. Wrap pulses are registered and line up
// with the count value that follows the wrap.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : counter_bank_param_if.slave (controls in, count/wrap out)
// Build option:
//   COUNTER_BANK_SATURATE_EN - counters hold at the terminal value instead of
//   wrapping; wrap_out then marks the edge on which saturation is entered.
module counter_bank_param #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  counter_bank_param_if.slave        bus
);

  localparam int TOTAL = WIDTH * CHANNELS;

  logic [TOTAL-1:0]    count_q;
  logic [TOTAL-1:0]    count_d;
  logic [CHANNELS-1:0] wrap_q;
  logic [CHANNELS-1:0] wrap_d;
  logic                all_wrap_q;
  logic [WIDTH-1:0]    term;
  logic [CHANNELS-1:0] at_term;
  logic [CHANNELS-1:0] step;
  logic                ripple;
`ifdef COUNTER_BANK_SATURATE_EN
  logic                bank_term;
  logic                next_bank_term;
`endif

  // Terminal value follows dir directly, so a direction change releases a
  // saturated channel without any extra state.
  assign term = bus.dir ? '0 : '1;

  always_comb begin
    at_term = '0;
    step    = '0;
    count_d = count_q;
    wrap_d  = '0;
    ripple  = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
    bank_term      = 1'b0;
    next_bank_term = 1'b1;
`endif

    for (int k = 0; k < CHANNELS; k++) begin
      at_term[k] = (count_q[k*WIDTH +: WIDTH] == term);
    end

    // Channel k steps when every lower channel sits at terminal (cascade),
    // which is exactly the carry/borrow of one wide counter.
    for (int k = 0; k < CHANNELS; k++) begin
      step[k] = bus.cascade ? ripple : 1'b1;
      ripple  = ripple & at_term[k];
    end

`ifdef COUNTER_BANK_SATURATE_EN
    // Cascade saturates as one wide counter: only the all-terminal bank stops.
    bank_term = &at_term;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.cascade ? bank_term : at_term[k]) begin
        step[k] = 1'b0;
      end
    end
`endif

    for (int k = 0; k < CHANNELS; k++) begin
      if (step[k]) begin
        if (bus.dir) begin
          count_d[k*WIDTH +: WIDTH] = count_q[k*WIDTH +: WIDTH] - WIDTH'(1);
        end else begin
          count_d[k*WIDTH +: WIDTH] = count_q[k*WIDTH +: WIDTH] + WIDTH'(1);
        end
      end
    end

`ifdef COUNTER_BANK_SATURATE_EN
    // Pulse on entry into saturation; a held channel never steps so it
    // cannot pulse again.
    for (int k = 0; k < CHANNELS; k++) begin
      next_bank_term = next_bank_term & (count_d[k*WIDTH +: WIDTH] == term);
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.cascade) begin
        wrap_d[k] = next_bank_term & ~bank_term;
      end else begin
        wrap_d[k] = step[k] & (count_d[k*WIDTH +: WIDTH] == term);
      end
    end
`else
    wrap_d = step & at_term;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      wrap_q     <= '0;
      all_wrap_q <= 1'b0;
    end else if (bus.load) begin
      count_q    <= bus.load_val;
      wrap_q     <= '0;
      all_wrap_q <= 1'b0;
    end else if (bus.en) begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      all_wrap_q <= &wrap_d;
    end else begin
      wrap_q     <= '0;
      all_wrap_q <= 1'b0;
    end
  end

  assign bus.count_out = count_q;
  assign bus.wrap_out  = wrap_q;
  assign bus.all_wrap  = all_wrap_q;

endmodule
